// File: rtl/bw_io_hstl_zcal_ctl.sv
// Impedance-calibration controller for HSTL pad drivers: steps a replica leg count
// against an external-resistor comparator and transfers locked codes to the drivers.
module bw_io_hstl_zcal_ctl #(
    parameter int SETTLE_CYC = 16,
    parameter int PERIOD     = 4096,
    parameter int RST_LEGS   = 4
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       cal_start,
    input  logic       auto_en,
    input  logic       cal_freeze,
    input  logic       zq_cmp_up,
    input  logic       zq_cmp_dn,
    output logic [7:0] rep_cbu,
    output logic [7:0] rep_cbd,
    output logic [7:0] cbu,
    output logic [7:0] cbd,
    output logic       cal_busy,
    output logic       cal_done,
    output logic       cal_err
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int PW = $clog2(PERIOD + 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
    localparam logic [3:0]    RST_N    = 4'(RST_LEGS);

    typedef enum logic [2:0] {
        S_IDLE, S_PU_SET, S_PU_SAMP, S_PD_SET, S_PD_SAMP, S_UPDATE
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    rep_u_q, rep_u_d, rep_d_q, rep_d_d;
    logic [3:0]    drv_u_q, drv_u_d, drv_d_q, drv_d_d;
    logic [3:0]    prev_q, prev_d;
    logic          hist_q, hist_d, dir_up_q, dir_up_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [PW-1:0] per_q, per_d;
    logic          up_s1_q, up_s2_q, dn_s1_q, dn_s2_q;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic       is_pu, inc, sat, rev, lock;
    logic [3:0] cur, nxt;

    function automatic logic [7:0] therm(input logic [3:0] n);
        logic [8:0] t;
        t = (9'd1 << n) - 9'd1;
        return t[7:0];
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        rep_u_d  = rep_u_q;
        rep_d_d  = rep_d_q;
        drv_u_d  = drv_u_q;
        drv_d_d  = drv_d_q;
        prev_d   = prev_q;
        hist_d   = hist_q;
        dir_up_d = dir_up_q;
        settle_d = settle_q;
        err_d    = err_q;
        done_d   = 1'b0;
        is_pu    = (state_q == S_PU_SAMP);
        cur      = is_pu ? rep_u_q : rep_d_q;
        inc      = is_pu ? up_s2_q : dn_s2_q;
        sat      = inc ? (cur == 4'd8) : (cur == 4'd0);
        rev      = hist_q && (dir_up_q != inc);
        lock     = 1'b0;
        nxt      = cur;

        if (!auto_en) begin
            per_d = '0;
        end else if (state_q == S_IDLE) begin
            per_d = per_q + PW'(1);
        end else begin
            per_d = per_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cal_start || (auto_en && per_q == PER_LAST)) begin
                    state_d  = S_PU_SET;
                    rep_u_d  = drv_u_q;
                    rep_d_d  = drv_d_q;
                    hist_d   = 1'b0;
                    err_d    = 1'b0;
                    settle_d = '0;
                    per_d    = '0;
                end
            end
            S_PU_SET, S_PD_SET: begin
                if (settle_q == SET_LAST) begin
                    settle_d = '0;
                    state_d  = (state_q == S_PU_SET) ? S_PU_SAMP : S_PD_SAMP;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_PU_SAMP, S_PD_SAMP: begin
                // A direction reversal means the comparator is dithering; keep the weaker code.
                if (sat) begin
                    lock  = 1'b1;
                    err_d = 1'b1;
                end else if (rev) begin
                    lock = 1'b1;
                    nxt  = (cur < prev_q) ? cur : prev_q;
                end else begin
                    nxt = inc ? cur + 4'd1 : cur - 4'd1;
                end
                if (lock) begin
                    hist_d  = 1'b0;
                    state_d = is_pu ? S_PD_SET : S_UPDATE;
                end else begin
                    hist_d   = 1'b1;
                    dir_up_d = inc;
                    prev_d   = cur;
                    state_d  = is_pu ? S_PU_SET : S_PD_SET;
                end
                if (is_pu) begin
                    rep_u_d = nxt;
                end else begin
                    rep_d_d = nxt;
                end
            end
            S_UPDATE: begin
                if (!cal_freeze) begin
                    drv_u_d = rep_u_q;
                    drv_d_d = rep_d_q;
                    done_d  = 1'b1;
                    per_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= S_IDLE;
            rep_u_q  <= RST_N;
            rep_d_q  <= RST_N;
            drv_u_q  <= RST_N;
            drv_d_q  <= RST_N;
            prev_q   <= '0;
            hist_q   <= 1'b0;
            dir_up_q <= 1'b0;
            settle_q <= '0;
            per_q    <= '0;
            up_s1_q  <= 1'b0;
            up_s2_q  <= 1'b0;
            dn_s1_q  <= 1'b0;
            dn_s2_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            rep_u_q  <= rep_u_d;
            rep_d_q  <= rep_d_d;
            drv_u_q  <= drv_u_d;
            drv_d_q  <= drv_d_d;
            prev_q   <= prev_d;
            hist_q   <= hist_d;
            dir_up_q <= dir_up_d;
            settle_q <= settle_d;
            per_q    <= per_d;
            up_s1_q  <= zq_cmp_up;
            up_s2_q  <= up_s1_q;
            dn_s1_q  <= zq_cmp_dn;
            dn_s2_q  <= dn_s1_q;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rep_cbu  = therm(rep_u_q);
    assign rep_cbd  = therm(rep_d_q);
    assign cbu      = therm(drv_u_q);
    assign cbd      = therm(drv_d_q);
    assign cal_busy = busy_q;
    assign cal_done = done_q;
    assign cal_err  = err_q;

endmodule

// File: tb/tb_bw_io_hstl_zcal_ctl.sv
// Self-checking bench: replica comparators modelled as leg-count thresholds, expected
// lock codes and latencies derived in closed form.
module tb_bw_io_hstl_zcal_ctl;

    localparam int S = 5;
    localparam int P = 64;

    logic       clk = 1'b0;
    logic       rst_l = 1'b1;
    logic       cal_start = 1'b0;
    logic       auto_en = 1'b0;
    logic       cal_freeze = 1'b0;
    logic       zq_cmp_up, zq_cmp_dn;
    logic [7:0] rep_cbu, rep_cbd, cbu, cbd;
    logic       cal_busy, cal_done, cal_err;

    int thr_u = 5;
    int thr_d = 5;
    int cur_u = 4;
    int cur_d = 4;
    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int viol = 0;
    bit mon_en = 1'b0;
    logic [7:0] prev_cbu = 8'h0F;
    logic [7:0] prev_cbd = 8'h0F;

    bw_io_hstl_zcal_ctl #(.SETTLE_CYC(S), .PERIOD(P), .RST_LEGS(4)) dut (
        .clk(clk), .rst_l(rst_l), .cal_start(cal_start), .auto_en(auto_en),
        .cal_freeze(cal_freeze), .zq_cmp_up(zq_cmp_up), .zq_cmp_dn(zq_cmp_dn),
        .rep_cbu(rep_cbu), .rep_cbd(rep_cbd), .cbu(cbu), .cbd(cbd),
        .cal_busy(cal_busy), .cal_done(cal_done), .cal_err(cal_err)
    );

    always #5 clk = ~clk;

    // Replica comparator: "too weak" while the replica has fewer legs than the threshold.
    assign zq_cmp_up = ($countones(rep_cbu) < thr_u);
    assign zq_cmp_dn = ($countones(rep_cbd) < thr_d);

    always @(negedge clk) begin
        prev_cbu <= cbu;
        prev_cbd <= cbd;
        if (cal_done) done_cnt <= done_cnt + 1;
        if (mon_en && !cal_done && (cbu !== prev_cbu || cbd !== prev_cbd)) viol <= viol + 1;
    end

    function automatic logic [7:0] therm(input int n);
        logic [8:0] t;
        t = (9'd1 << n) - 9'd1;
        return t[7:0];
    endfunction

    // Search from n0 against threshold thr settles one leg below thr, or saturates.
    function automatic void exp_cal(input int n0, input int thr,
                                    output int lock, output int samples, output bit err);
        if (thr > n0) begin
            if (thr > 8) begin lock = 8; err = 1'b1; samples = 9 - n0; end
            else begin lock = thr - 1; err = 1'b0; samples = thr - n0 + 1; end
        end else begin
            if (thr <= 0) begin lock = 0; err = 1'b1; samples = n0 + 1; end
            else begin lock = thr - 1; err = 1'b0; samples = n0 - thr + 2; end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cal(input int tu, input int td, input bit poke, input bit hold);
        int lu, ku, ld, kd, lat, m, d0;
        bit eu, ed;
        thr_u = tu;
        thr_d = td;
        exp_cal(cur_u, tu, lu, ku, eu);
        exp_cal(cur_d, td, ld, kd, ed);
        lat = (ku + kd) * (S + 1) + 1;
        d0 = done_cnt;
        cal_freeze = hold;
        @(negedge clk) cal_start = 1'b1;
        @(posedge clk);
        @(negedge clk) cal_start = 1'b0;
        check("busy_on_start", cal_busy, 1);
        check("err_cleared_on_start", cal_err, 0);
        m = 0;
        while (m < lat + 30 && !cal_done) begin
            @(posedge clk);
            @(negedge clk);
            m++;
            if (poke) cal_start = (m == 3);
            if (ku > 1 && m == S) check("rep_before_first_step", rep_cbu, therm(cur_u));
            if (ku > 1 && m == S + 1)
                check("rep_first_step", rep_cbu, therm(cur_u + ((tu > cur_u) ? 1 : -1)));
        end
        cal_start = 1'b0;
        if (hold) begin
            check("freeze_no_done", cal_done, 0);
            check("freeze_busy", cal_busy, 1);
            check("freeze_cbu_held", cbu, therm(cur_u));
            check("freeze_cbd_held", cbd, therm(cur_d));
            cal_freeze = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("unfreeze_done", cal_done, 1);
        end else begin
            check("cal_latency", m, lat);
        end
        check("cbu_locked", cbu, therm(lu));
        check("cbd_locked", cbd, therm(ld));
        check("cal_err", cal_err, eu | ed);
        cur_u = lu;
        cur_d = ld;
        repeat (4) @(negedge clk);
        check("single_done_pulse", done_cnt - d0, 1);
        check("idle_after_done", cal_busy, 0);
    endtask

    initial begin
        int m, lu, ku, ld, kd;
        bit eu, ed;
        #1 rst_l = 1'b0;
        #3;
        check("rst_cbu", cbu, 8'h0F);
        check("rst_cbd", cbd, 8'h0F);
        check("rst_rep_cbu", rep_cbu, 8'h0F);
        check("rst_rep_cbd", rep_cbd, 8'h0F);
        check("rst_busy", cal_busy, 0);
        check("rst_done", cal_done, 0);
        check("rst_err", cal_err, 0);
        @(negedge clk) rst_l = 1'b1;
        @(negedge clk) mon_en = 1'b1;

        // Pull-up locks at 5 legs (1F), pull-down at 2 legs (03); a stray start is dropped.
        run_cal(6, 3, 1'b1, 1'b0);
        // Pull-up comparator stuck high: saturates at 8 legs.
        run_cal(9, 3, 1'b0, 1'b0);
        // Calibration under freeze waits in UPDATE; also clears the sticky error.
        run_cal(5, 5, 1'b0, 1'b1);

        // Periodic recalibration around 4 legs must not drift.
        thr_u = 5;
        thr_d = 5;
        auto_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            m = 0;
            while (m < 400 && !cal_done) begin @(negedge clk); m++; end
            check("auto_done_seen", cal_done, 1);
            check("auto_cbu_stable", cbu, 8'h0F);
            check("auto_cbd_stable", cbd, 8'h0F);
            m = 0;
            while (m < 200 && !cal_busy) begin @(negedge clk); m++; end
            check("auto_period", m, P);
        end
        auto_en = 1'b0;
        m = 0;
        while (m < 400 && !cal_done) begin @(negedge clk); m++; end
        @(negedge clk);

        run_cal(7, 7, 1'b0, 1'b0);

        // Asynchronous reset while in the first PD_SAMP cycle.
        thr_u = 3;
        thr_d = 8;
        exp_cal(cur_u, thr_u, lu, ku, eu);
        exp_cal(cur_d, thr_d, ld, kd, ed);
        @(negedge clk) cal_start = 1'b1;
        @(posedge clk);
        @(negedge clk) cal_start = 1'b0;
        repeat (ku * (S + 1) + S) @(negedge clk);
        check("pu_locked_before_rst", rep_cbu, therm(lu));
        check("cbu_before_rst", cbu, therm(cur_u));
        mon_en = 1'b0;
        rst_l = 1'b0;
        #1;
        check("midcal_rst_cbu", cbu, 8'h0F);
        check("midcal_rst_cbd", cbd, 8'h0F);
        check("midcal_rst_rep_cbu", rep_cbu, 8'h0F);
        check("midcal_rst_busy", cal_busy, 0);
        cur_u = 4;
        cur_d = 4;
        @(negedge clk) rst_l = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_cal(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                    bit'($urandom_range(0, 1)), 1'b0);
        end

        check("cbu_cbd_only_change_on_done", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
